// File: rtl/vga_timing_gen_if.sv
// Raster bus between the VGA timing source, the sprite drawers and the DAC pins.
// master = timing generator, slave = drawer/DAC side.
interface vga_timing_gen_if;
    localparam int unsigned COORD_W = 11;

    logic                 drawing_request;
    logic [7:0]           mVGA_RGB;
    logic [COORD_W-1:0]   oCoord_X;
    logic [COORD_W-1:0]   oCoord_Y;
    logic                 startOfFrame;
    logic                 VGA_HS;
    logic                 VGA_VS;
    logic                 VGA_BLANK_N;
    logic [7:0]           VGA_R;
    logic [7:0]           VGA_G;
    logic [7:0]           VGA_B;

    modport master (
        input  drawing_request, mVGA_RGB,
        output oCoord_X, oCoord_Y, startOfFrame,
        output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        output drawing_request, mVGA_RGB,
        input  oCoord_X, oCoord_Y, startOfFrame,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing source: issues pixel coordinates to the drawers, realigns their
// response through a PIPE_LAT-deep sync delay line and registers sync/blank/RGB pins.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_LAT = 1,
    parameter logic [7:0]  BG_COLOR = 8'h00
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PIX_EN,
    vga_timing_gen_if.master  bus
);
    localparam int unsigned CW       = 11;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    // Delay-line word is {act, hs_n, vs_n}; idle means blanked with both syncs released.
    localparam logic [2:0]  DLY_IDLE = 3'b011;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          act0;
    logic          hs0_n;
    logic          vs0_n;
    logic [2:0]    dly [PIPE_LAT];
    logic          tap_act;
    logic          tap_hs_n;
    logic          tap_vs_n;
    logic [7:0]    pix_c;
    logic [7:0]    r_nxt;
    logic [7:0]    g_nxt;
    logic [7:0]    b_nxt;

    assign h_last = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt == CW'(V_TOTAL - 1));

    // Raster counters; the vertical count only moves on a horizontal wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (PIX_EN) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + CW'(1);
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
        end
    end

    assign bus.oCoord_X     = h_cnt;
    assign bus.oCoord_Y     = v_cnt;
    assign bus.startOfFrame = (h_cnt == '0) && (v_cnt == '0) && PIX_EN && !RESET;

    // Stage-0 decode of the current coordinate.
    assign act0  = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
    assign hs0_n = !((h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_END)));
    assign vs0_n = !((v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_END)));

    // Delay line matching the drawer latency so sync/blank meet their own pixel colour.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                dly[i] <= DLY_IDLE;
            end
        end else if (PIX_EN) begin
            dly[0] <= {act0, hs0_n, vs0_n};
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign {tap_act, tap_hs_n, tap_vs_n} = dly[PIPE_LAT-1];

    // RGB332 to 8-bit-per-channel expansion; forced black outside the active area.
    always_comb begin
        pix_c = BG_COLOR;
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (bus.drawing_request) begin
            pix_c = bus.mVGA_RGB;
        end
        if (tap_act) begin
            r_nxt = {pix_c[7:5], pix_c[7:5], pix_c[7:6]};
            g_nxt = {pix_c[4:2], pix_c[4:2], pix_c[4:3]};
            b_nxt = {pix_c[1:0], pix_c[1:0], pix_c[1:0], pix_c[1:0]};
        end
    end

    // Pin register: one extra tick after the delay-line tap for every pin.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.VGA_HS      <= 1'b1;
            bus.VGA_VS      <= 1'b1;
            bus.VGA_BLANK_N <= 1'b0;
            bus.VGA_R       <= '0;
            bus.VGA_G       <= '0;
            bus.VGA_B       <= '0;
        end else if (PIX_EN) begin
            bus.VGA_HS      <= tap_hs_n;
            bus.VGA_VS      <= tap_vs_n;
            bus.VGA_BLANK_N <= tap_act;
            bus.VGA_R       <= r_nxt;
            bus.VGA_G       <= g_nxt;
            bus.VGA_B       <= b_nxt;
        end
    end
endmodule
